// File: rtl/code_lock_pkg.sv
// Shared definitions for the code_lock keypad lock.
// Holds the FSM state encoding, the state width and a counter-width helper
// used by code_lock and code_lock_entry_buf.
package code_lock_pkg;

    localparam int unsigned STATE_W = 3;

    // Encoding is visible on the state output port, so the values are fixed.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_FAIL    = 3'd4,
        S_LOCKOUT = 3'd5,
        S_SET     = 3'd6
    } state_e;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/code_lock_entry_buf.sv
// Digit entry buffer for code_lock.
// Shifts accepted digits in at the least significant end, so the first digit
// entered ends up most significant once CODE_LEN digits are collected.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       empty the buffer and zero the digit count (wins over shift)
//   shift       append digit to the buffer and bump the count
//   digit       digit value to append
//   data        registered buffer contents
//   shifted_c   buffer contents as they would be after appending digit
//   last_c      high when the next appended digit completes a full code
module code_lock_entry_buf
    import code_lock_pkg::*;
#(
    parameter int unsigned DIGIT_W  = 4,
    parameter int unsigned CODE_LEN = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        shift,
    input  logic [DIGIT_W-1:0]          digit,
    output logic [CODE_LEN*DIGIT_W-1:0] data,
    output logic [CODE_LEN*DIGIT_W-1:0] shifted_c,
    output logic                        last_c
);

    localparam int unsigned BUF_W = CODE_LEN * DIGIT_W;
    localparam int unsigned CNT_W = cnt_width(CODE_LEN);

    logic [CNT_W-1:0] count;

    // Shift form works for CODE_LEN=1 as well, where the old contents drop out.
    assign shifted_c = (data << DIGIT_W) | BUF_W'(digit);
    assign last_c    = (count == CNT_W'(CODE_LEN - 1));

    // Buffer and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            count <= '0;
        end else if (clear) begin
            data  <= '0;
            count <= '0;
        end else if (shift) begin
            data  <= shifted_c;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/code_lock.sv
// Keypad code lock.
// Digits are accepted on rising edges of confirm and collected into a code.
// A matching code opens the lock; in OPEN, set_req starts entry of a new code.
// Optional feature macro: CODE_LOCK_ALARM_EN
//   defined   - limited tries, LOCKOUT state with timer, alarm output
//   undefined - mismatches always go to FAIL, right and alarm read zero
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous active-low reset
//   confirm   digit-accept strobe, only its rising edge counts
//   set_req   request code change, honoured only in OPEN
//   in        digit value
//   state     FSM state code
//   left      last accepted digit
//   right     tries remaining (zero without the alarm feature)
//   unlocked  high in OPEN
//   alarm     high in LOCKOUT
module code_lock
    import code_lock_pkg::*;
#(
    parameter int unsigned                 DIGIT_W        = 4,
    parameter int unsigned                 CODE_LEN       = 2,
    parameter int unsigned                 MAX_TRIES      = 3,
    parameter int unsigned                 LOCKOUT_CYCLES = 16,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 8'hA5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               confirm,
    input  logic               set_req,
    input  logic [DIGIT_W-1:0] in,
    output logic [STATE_W-1:0] state,
    output logic [DIGIT_W-1:0] left,
    output logic [DIGIT_W-1:0] right,
    output logic               unlocked,
    output logic               alarm
);

    localparam int unsigned BUF_W = CODE_LEN * DIGIT_W;

    // Reject parameter sets the datapath cannot represent.
    if (CODE_LEN == 0 || LOCKOUT_CYCLES == 0 || MAX_TRIES == 0 ||
        MAX_TRIES >= (1 << DIGIT_W)) begin : g_bad_cfg
        $error("code_lock: illegal parameter combination");
    end

    state_e             state_q;
    state_e             state_d;
    logic               conf_q;
    logic               accept_c;
    logic [BUF_W-1:0]   code_q;
    logic [BUF_W-1:0]   code_d;
    logic [DIGIT_W-1:0] left_d;

    logic               buf_clear_c;
    logic               buf_shift_c;
    logic [BUF_W-1:0]   entry_data;
    logic [BUF_W-1:0]   entry_shifted_c;
    logic               entry_last_c;

`ifdef CODE_LOCK_ALARM_EN
    localparam int unsigned TMR_W = cnt_width(LOCKOUT_CYCLES);

    logic [DIGIT_W-1:0] tries_q;
    logic [DIGIT_W-1:0] tries_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic               alarm_q;
`endif

    // A held confirm only produces one accept.
    assign accept_c = confirm & ~conf_q;

    code_lock_entry_buf #(
        .DIGIT_W  (DIGIT_W),
        .CODE_LEN (CODE_LEN)
    ) u_entry_buf (
        .clk       (clock),
        .rst_n     (reset),
        .clear     (buf_clear_c),
        .shift     (buf_shift_c),
        .digit     (in),
        .data      (entry_data),
        .shifted_c (entry_shifted_c),
        .last_c    (entry_last_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        left_d      = left;
        buf_clear_c = 1'b0;
        buf_shift_c = 1'b0;
`ifdef CODE_LOCK_ALARM_EN
        tries_d     = tries_q;
        timer_d     = timer_q;
`endif

        case (state_q)
            S_IDLE, S_ENTRY: begin
                if (accept_c) begin
                    buf_shift_c = 1'b1;
                    left_d      = in;
                    state_d     = entry_last_c ? S_CHECK : S_ENTRY;
                end
            end

            // Single-cycle compare; confirm edges here are dropped.
            S_CHECK: begin
                buf_clear_c = 1'b1;
                if (entry_data == code_q) begin
                    state_d = S_OPEN;
`ifdef CODE_LOCK_ALARM_EN
                    tries_d = DIGIT_W'(MAX_TRIES);
`endif
                end else begin
`ifdef CODE_LOCK_ALARM_EN
                    tries_d = tries_q - DIGIT_W'(1);
                    if (tries_d == '0) begin
                        state_d = S_LOCKOUT;
                        timer_d = TMR_W'(LOCKOUT_CYCLES);
                    end else begin
                        state_d = S_FAIL;
                    end
`else
                    state_d = S_FAIL;
`endif
                end
            end

            S_FAIL: begin
                buf_clear_c = 1'b1;
                state_d     = S_IDLE;
            end

            // set_req takes priority over a simultaneous digit.
            S_OPEN: begin
                if (set_req) begin
                    state_d = S_SET;
                end else if (accept_c) begin
                    left_d  = in;
                    state_d = S_IDLE;
                end
            end

            // The final digit goes straight into the stored code.
            S_SET: begin
                if (accept_c) begin
                    left_d = in;
                    if (entry_last_c) begin
                        code_d      = entry_shifted_c;
                        buf_clear_c = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        buf_shift_c = 1'b1;
                    end
                end
            end

            S_LOCKOUT: begin
`ifdef CODE_LOCK_ALARM_EN
                if (timer_q <= TMR_W'(1)) begin
                    timer_d = '0;
                    tries_d = DIGIT_W'(MAX_TRIES);
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
`else
                state_d = S_IDLE;
`endif
            end

            default: begin
                buf_clear_c = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            conf_q   <= 1'b0;
            code_q   <= DEFAULT_CODE;
            left     <= '0;
            unlocked <= 1'b0;
`ifdef CODE_LOCK_ALARM_EN
            tries_q  <= DIGIT_W'(MAX_TRIES);
            timer_q  <= '0;
            alarm_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            conf_q   <= confirm;
            code_q   <= code_d;
            left     <= left_d;
            unlocked <= (state_d == S_OPEN);
`ifdef CODE_LOCK_ALARM_EN
            tries_q  <= tries_d;
            timer_q  <= timer_d;
            alarm_q  <= (state_d == S_LOCKOUT);
`endif
        end
    end

    assign state = state_q;

`ifdef CODE_LOCK_ALARM_EN
    assign right = tries_q;
    assign alarm = alarm_q;
`else
    assign right = '0;
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_code_lock.sv
// Self-checking bench for code_lock (default parameters).
module tb_code_lock;

    localparam int DIGIT_W        = 4;
    localparam int CODE_LEN       = 2;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 16;

`ifdef CODE_LOCK_ALARM_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif
    localparam logic [3:0] EXP_MAX = ALARM_EN ? 4'(MAX_TRIES) : 4'd0;

    logic       clock = 1'b0;
    logic       reset;
    logic       confirm;
    logic       set_req;
    logic [3:0] din;
    logic [2:0] state;
    logic [3:0] left;
    logic [3:0] right;
    logic       unlocked;
    logic       alarm;

    int checks   = 0;
    int failures = 0;

    // Reference model: digits kept as queues, states as the published codes.
    int         m_st;
    bit         m_cq;
    logic [3:0] m_digits[$];
    logic [3:0] m_code[$];
    int         m_tries;
    int         m_timer;
    logic [3:0] m_left;

    code_lock #(
        .DIGIT_W        (DIGIT_W),
        .CODE_LEN       (CODE_LEN),
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .DEFAULT_CODE   (8'hA5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .confirm  (confirm),
        .set_req  (set_req),
        .in       (din),
        .state    (state),
        .left     (left),
        .right    (right),
        .unlocked (unlocked),
        .alarm    (alarm)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        m_st    = 0;
        m_cq    = 1'b0;
        m_digits.delete();
        m_code.delete();
        m_code.push_back(4'hA);
        m_code.push_back(4'h5);
        m_tries = MAX_TRIES;
        m_timer = 0;
        m_left  = 4'h0;
    endfunction

    function automatic void model_step(input bit c, input bit s, input logic [3:0] d);
        bit acc;
        bit ok;
        acc  = c && !m_cq;
        m_cq = c;
        case (m_st)
            0, 1: if (acc) begin
                m_digits.push_back(d);
                m_left = d;
                m_st   = (m_digits.size() == CODE_LEN) ? 2 : 1;
            end
            2: begin
                ok = 1'b1;
                for (int i = 0; i < CODE_LEN; i++)
                    if (m_digits[i] !== m_code[i]) ok = 1'b0;
                m_digits.delete();
                if (ok) begin
                    m_st    = 3;
                    m_tries = MAX_TRIES;
                end else if (ALARM_EN) begin
                    m_tries = m_tries - 1;
                    if (m_tries == 0) begin
                        m_st    = 5;
                        m_timer = LOCKOUT_CYCLES;
                    end else begin
                        m_st = 4;
                    end
                end else begin
                    m_st = 4;
                end
            end
            3: if (s) m_st = 6;
               else if (acc) begin
                   m_left = d;
                   m_st   = 0;
               end
            4: begin
                m_digits.delete();
                m_st = 0;
            end
            5: begin
                m_timer = m_timer - 1;
                if (m_timer == 0) begin
                    m_st    = 0;
                    m_tries = MAX_TRIES;
                end
            end
            6: if (acc) begin
                m_left = d;
                m_digits.push_back(d);
                if (m_digits.size() == CODE_LEN) begin
                    m_code = m_digits;
                    m_digits.delete();
                    m_st = 0;
                end
            end
            default: m_st = 0;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic step_clk(input logic c, input logic s, input logic [3:0] d);
        confirm = c;
        set_req = s;
        din     = d;
        @(posedge clock);
        model_step(c, s, d);
        #1;
    endtask

    task automatic assert_reset();
        confirm = 1'b0;
        set_req = 1'b0;
        din     = 4'h0;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        #2;
        reset = 1'b1;
        @(posedge clock);
        model_step(1'b0, 1'b0, 4'h0);
        #1;
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    // Two digits then the CHECK cycle; ends sampled just after CHECK.
    task automatic enter_code(input logic [3:0] d0, input logic [3:0] d1);
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, d0);
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, d1);
        step_clk(1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        confirm = 1'b0;
        set_req = 1'b0;
        din     = 4'h0;
        model_reset();
        #2;
        checks++;
        if (state !== 3'd0 || left !== 4'h0 || unlocked !== 1'b0 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs state=%0d left=%0h unlocked=%0b alarm=%0b, expected 0/0/0/0",
                     state, left, unlocked, alarm);
        end
        checks++;
        if (right !== EXP_MAX) begin
            failures++;
            $display("FAIL reset_right got=%0d expected=%0d", right, EXP_MAX);
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        model_step(1'b0, 1'b0, 4'h0);
        #1;
    endtask

    task automatic test_open();
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'hA);
        checks++;
        if (state !== 3'd1 || left !== 4'hA) begin
            failures++;
            $display("FAIL open_first_digit state=%0d left=%0h, expected 1/a", state, left);
        end
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'h5);
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL open_check state=%0d expected=2", state);
        end
        step_clk(1'b0, 1'b0, 4'h0);
        checks++;
        if (state !== 3'd3 || unlocked !== 1'b1 || right !== EXP_MAX) begin
            failures++;
            $display("FAIL open_state state=%0d unlocked=%0b right=%0d, expected 3/1/%0d",
                     state, unlocked, right, EXP_MAX);
        end
        step_clk(1'b0, 1'b0, 4'h0);
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL open_hold state=%0d expected=3", state);
        end
        step_clk(1'b1, 1'b0, 4'h7);
        checks++;
        if (state !== 3'd0 || unlocked !== 1'b0) begin
            failures++;
            $display("FAIL open_relock state=%0d unlocked=%0b, expected 0/0", state, unlocked);
        end
    endtask

    task automatic test_wrong();
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'hF);
        step_clk(1'b1, 1'b0, 4'hA);
        checks++;
        if (state !== 3'd1 || left !== 4'hF) begin
            failures++;
            $display("FAIL wrong_held_confirm state=%0d left=%0h, expected 1/f", state, left);
        end
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'hA);
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL wrong_check state=%0d expected=2", state);
        end
        step_clk(1'b0, 1'b0, 4'h0);
        checks++;
        if (state !== 3'd4 || right !== (ALARM_EN ? 4'd2 : 4'd0) || unlocked !== 1'b0) begin
            failures++;
            $display("FAIL wrong_fail state=%0d right=%0d unlocked=%0b, expected 4/%0d/0",
                     state, right, unlocked, ALARM_EN ? 2 : 0);
        end
        step_clk(1'b1, 1'b0, 4'h3);
        step_clk(1'b0, 1'b0, 4'h0);
        checks++;
        if (state !== 3'd0 || left !== 4'hA) begin
            failures++;
            $display("FAIL wrong_fail_drop state=%0d left=%0h, expected 0/a", state, left);
        end
    endtask

    task automatic test_lockout();
        int alarm_cnt;
        enter_code(4'hF, 4'hF);
        enter_code(4'hF, 4'hF);
        checks++;
        if (state !== (ALARM_EN ? 3'd5 : 3'd4) || alarm !== ALARM_EN) begin
            failures++;
            $display("FAIL lockout_entry state=%0d alarm=%0b, expected %0d/%0b",
                     state, alarm, ALARM_EN ? 5 : 4, ALARM_EN);
        end
        alarm_cnt = (alarm === 1'b1) ? 1 : 0;
        for (int i = 0; i < LOCKOUT_CYCLES; i++) begin
            step_clk((i % 2) == 0, 1'b1, 4'h7);
            if (alarm === 1'b1) alarm_cnt++;
            checks++;
            if (state !== 3'(m_st)) begin
                failures++;
                $display("FAIL lockout_state i=%0d got=%0d expected=%0d", i, state, m_st);
            end
        end
        checks++;
        if (alarm_cnt != (ALARM_EN ? LOCKOUT_CYCLES : 0)) begin
            failures++;
            $display("FAIL lockout_alarm_cycles got=%0d expected=%0d",
                     alarm_cnt, ALARM_EN ? LOCKOUT_CYCLES : 0);
        end
        checks++;
        if (alarm !== 1'b0 || right !== (ALARM_EN ? 4'(m_tries) : 4'd0)) begin
            failures++;
            $display("FAIL lockout_exit alarm=%0b right=%0d, expected 0/%0d",
                     alarm, right, ALARM_EN ? m_tries : 0);
        end
    endtask

    task automatic test_set_code();
        do_reset();
        enter_code(4'hA, 4'h5);
        step_clk(1'b1, 1'b1, 4'h9);
        checks++;
        if (state !== 3'd6 || unlocked !== 1'b0 || left !== 4'h5) begin
            failures++;
            $display("FAIL set_enter state=%0d unlocked=%0b left=%0h, expected 6/0/5",
                     state, unlocked, left);
        end
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'h3);
        checks++;
        if (state !== 3'd6 || left !== 4'h3) begin
            failures++;
            $display("FAIL set_digit state=%0d left=%0h, expected 6/3", state, left);
        end
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'hC);
        checks++;
        if (state !== 3'd0 || left !== 4'hC) begin
            failures++;
            $display("FAIL set_done state=%0d left=%0h, expected 0/c", state, left);
        end
        enter_code(4'hA, 4'h5);
        checks++;
        if (state !== 3'd4 || right !== (ALARM_EN ? 4'd2 : 4'd0)) begin
            failures++;
            $display("FAIL set_old_code state=%0d right=%0d, expected 4/%0d",
                     state, right, ALARM_EN ? 2 : 0);
        end
        enter_code(4'h3, 4'hC);
        checks++;
        if (state !== 3'd3 || unlocked !== 1'b1 || right !== EXP_MAX) begin
            failures++;
            $display("FAIL set_new_code state=%0d unlocked=%0b right=%0d, expected 3/1/%0d",
                     state, unlocked, right, EXP_MAX);
        end
    endtask

    task automatic test_async_reset();
        // Mid-entry reset with a changed code; code must revert.
        do_reset();
        enter_code(4'hA, 4'h5);
        step_clk(1'b1, 1'b1, 4'h0);
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'h3);
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'hC);
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b1, 1'b0, 4'h4);
        checks++;
        if (state !== 3'd1) begin
            failures++;
            $display("FAIL arst_pre_entry state=%0d expected=1", state);
        end
        assert_reset();
        checks++;
        if (state !== 3'd0 || left !== 4'h0 || right !== EXP_MAX || unlocked !== 1'b0 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL arst_entry state=%0d left=%0h right=%0d unlocked=%0b alarm=%0b, expected 0/0/%0d/0/0",
                     state, left, right, unlocked, alarm, EXP_MAX);
        end
        release_reset();
        enter_code(4'hA, 4'h5);
        checks++;
        if (state !== 3'd3) begin
            failures++;
            $display("FAIL arst_code_restored state=%0d expected=3", state);
        end
        // Mid-lockout reset.
        do_reset();
        enter_code(4'hF, 4'h1);
        enter_code(4'hF, 4'h1);
        enter_code(4'hF, 4'h1);
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b0, 1'b0, 4'h0);
        step_clk(1'b0, 1'b0, 4'h0);
        checks++;
        if (state !== (ALARM_EN ? 3'd5 : 3'd0)) begin
            failures++;
            $display("FAIL arst_pre_lockout state=%0d expected=%0d", state, ALARM_EN ? 5 : 0);
        end
        assert_reset();
        checks++;
        if (state !== 3'd0 || left !== 4'h0 || right !== EXP_MAX || unlocked !== 1'b0 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL arst_lockout state=%0d left=%0h right=%0d unlocked=%0b alarm=%0b, expected 0/0/%0d/0/0",
                     state, left, right, unlocked, alarm, EXP_MAX);
        end
        release_reset();
    endtask

    task automatic test_no_lockout();
        bit saw_lock;
        bit saw_alarm;
        do_reset();
        saw_lock  = 1'b0;
        saw_alarm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 6; j++) begin
                step_clk((j == 1) || (j == 3), 1'b0, 4'hF);
                if (state === 3'd5) saw_lock = 1'b1;
                if (alarm === 1'b1) saw_alarm = 1'b1;
            end
            if (k == 0) begin
                checks++;
                if (right !== (ALARM_EN ? 4'd2 : 4'd0)) begin
                    failures++;
                    $display("FAIL nolock_first_right got=%0d expected=%0d", right, ALARM_EN ? 2 : 0);
                end
            end
        end
        checks++;
        if (saw_lock !== ALARM_EN || saw_alarm !== ALARM_EN) begin
            failures++;
            $display("FAIL nolock_seen lockout=%0b alarm=%0b, expected %0b/%0b",
                     saw_lock, saw_alarm, ALARM_EN, ALARM_EN);
        end
        checks++;
        if (state !== (ALARM_EN ? 3'd5 : 3'd0) || right !== 4'd0) begin
            failures++;
            $display("FAIL nolock_final state=%0d right=%0d, expected %0d/0",
                     state, right, ALARM_EN ? 5 : 0);
        end
    endtask

    task automatic test_random();
        int         idx;
        logic       c;
        logic       s;
        logic [3:0] d;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            idx = m_digits.size();
            if (idx >= CODE_LEN) idx = 0;
            c = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 9) == 0);
            d = ($urandom_range(0, 2) != 0) ? m_code[idx] : 4'($urandom_range(0, 15));
            step_clk(c, s, d);
            checks++;
            if (state !== 3'(m_st)) begin
                failures++;
                $display("FAIL rand_state cyc=%0d got=%0d expected=%0d", i, state, m_st);
            end
            checks++;
            if (left !== m_left) begin
                failures++;
                $display("FAIL rand_left cyc=%0d got=%0h expected=%0h", i, left, m_left);
            end
            checks++;
            if (right !== (ALARM_EN ? 4'(m_tries) : 4'd0)) begin
                failures++;
                $display("FAIL rand_right cyc=%0d got=%0d expected=%0d", i, right, ALARM_EN ? m_tries : 0);
            end
            checks++;
            if (unlocked !== (m_st == 3) || alarm !== (m_st == 5)) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d unlocked=%0b alarm=%0b, expected %0b/%0b",
                         i, unlocked, alarm, m_st == 3, m_st == 5);
            end
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_wrong();
        test_lockout();
        test_set_code();
        test_async_reset();
        test_no_lockout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
